// File: rtl/bmp_pixel_streamer_pkg.sv
// Shared types and constants for the BMP pixel streamer.
// Defines the FSM and byte-phase encodings and the 24-bit BMP byte order.
package bmp_stream_pkg;

    localparam int DEFAULT_ADDR_W = 23;

    // 24-bit BMP pixels are stored B, G, R at ascending byte addresses
    localparam logic [1:0] BMP_OFS_B = 2'd0;
    localparam logic [1:0] BMP_OFS_G = 2'd1;
    localparam logic [1:0] BMP_OFS_R = 2'd2;
    localparam int BYTES_PER_PX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PH_B = BMP_OFS_B,
        PH_G = BMP_OFS_G,
        PH_R = BMP_OFS_R
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_B:    return PH_G;
            PH_G:    return PH_R;
            default: return PH_B;
        endcase
    endfunction

endpackage

// File: rtl/bmp_pixel_streamer_if.sv
// Memory read port and Sobel camera port of the BMP pixel streamer.
// master is the streamer side; slave is the memory / Sobel side.
interface bmp_pixel_streamer_if #(
    parameter int ADDR_W = bmp_stream_pkg::DEFAULT_ADDR_W
);
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic [7:0]        cam_red_o;
    logic [7:0]        cam_green_o;
    logic [7:0]        cam_blue_o;
    logic              cam_done_o;

    modport master (
        output mem_rd_o, mem_addr_o,
        output cam_red_o, cam_green_o, cam_blue_o, cam_done_o,
        input  mem_data_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o,
        input  cam_red_o, cam_green_o, cam_blue_o, cam_done_o,
        output mem_data_i
    );
endinterface

// File: rtl/bgr_byte_assembler.sv
// Collects returned B and G bytes and emits a full RGB pixel on the R byte.
// Pixel outputs hold their value between strobes.
module bgr_byte_assembler
    import bmp_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vld,
    input  phase_t     ph,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       done
);
    logic [7:0] b_q;
    logic [7:0] g_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q   <= '0;
            g_q   <= '0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (vld) begin
                case (ph)
                    PH_B: b_q <= data;
                    PH_G: g_q <= data;
                    PH_R: begin
                        red   <= data;
                        green <= g_q;
                        blue  <= b_q;
                        done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/bmp_pixel_streamer.sv
// Reads 24-bit BMP pixel bytes from a byte-wide synchronous memory
// and streams one RGB pixel per strobe to the Sobel stage.
module bmp_pixel_streamer
    import bmp_stream_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W-1:0]    pixel_count_i,
    input  logic                 pause_i,
    bmp_pixel_streamer_if.master bus,
    output logic                 busy_o,
    output logic                 frame_done_o
);
    // Two extra bits hold 3*count without overflow
    localparam int CNT_W = ADDR_W + 2;

    state_t            state;
    state_t            state_nxt;
    phase_t            phase;
    phase_t            phase_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  byte_idx;
    logic [CNT_W-1:0]  last_idx;
    logic [CNT_W-1:0]  cnt_ext;
    logic              rd;
    logic              rd_q;
    logic              start_ok;
    logic              start_zero;
    logic              last_byte;
    logic              frame_done_d;
    logic              cam_done;
    logic [7:0]        cam_r;
    logic [7:0]        cam_g;
    logic [7:0]        cam_b;

    assign cnt_ext    = CNT_W'(pixel_count_i);
    assign start_ok   = start_i && (pixel_count_i != '0);
    assign start_zero = start_i && (pixel_count_i == '0);
    assign last_byte  = (byte_idx == last_idx);
    assign rd_addr    = base_q + byte_idx[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_o <= frame_done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = READ;
            READ:    if (rd && last_byte) state_nxt = DRAIN;
            DRAIN:   if (cam_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd           = (state == READ) && !pause_i;
        busy_o       = (state != IDLE);
        frame_done_d = ((state == IDLE) && start_zero)
                    || ((state == DRAIN) && cam_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            last_idx <= '0;
            byte_idx <= '0;
            phase    <= PH_B;
            addr_q   <= '0;
        end else if ((state == IDLE) && start_ok) begin
            base_q   <= base_addr_i;
            last_idx <= (cnt_ext << 1) + cnt_ext - CNT_W'(1);
            byte_idx <= '0;
            phase    <= PH_B;
        end else if (rd) begin
            byte_idx <= byte_idx + CNT_W'(1);
            phase    <= next_phase(phase);
            addr_q   <= rd_addr;
        end
    end

    // Read data returns one cycle after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= 1'b0;
            phase_q <= PH_B;
        end else begin
            rd_q    <= rd;
            phase_q <= phase;
        end
    end

    assign bus.mem_rd_o   = rd;
    assign bus.mem_addr_o = rd ? rd_addr : addr_q;

    bgr_byte_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .vld   (rd_q),
        .ph    (phase_q),
        .data  (bus.mem_data_i),
        .red   (cam_r),
        .green (cam_g),
        .blue  (cam_b),
        .done  (cam_done)
    );

    assign bus.cam_red_o   = cam_r;
    assign bus.cam_green_o = cam_g;
    assign bus.cam_blue_o  = cam_b;
    assign bus.cam_done_o  = cam_done;

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// Testbench for bmp_pixel_streamer: event-schedule reference model,
// directed frames and randomized frames with pause and stray starts.
module tb_bmp_pixel_streamer;
    import bmp_stream_pkg::*;

    localparam int AW = DEFAULT_ADDR_W;

    typedef struct {
        int         at;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    typedef struct {
        int          at;
        logic [AW-1:0] a;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW-1:0] pixel_count_i = '0;
    logic          pause_i = 1'b0;
    logic          busy_o;
    logic          frame_done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bmp_pixel_streamer_if #(.ADDR_W(AW)) bus ();

    bmp_pixel_streamer #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .pixel_count_i (pixel_count_i),
        .pause_i       (pause_i),
        .bus           (bus),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_at(input logic [AW-1:0] a);
        if (a >= 54 && a <= 59) return 8'((a - 53) * 10);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
    endfunction

    // Synchronous byte memory; junk on the bus when no read was issued
    initial bus.mem_data_i = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_rd_o === 1'b1) bus.mem_data_i <= mem_at(bus.mem_addr_o);
        else bus.mem_data_i <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: frame progress as counts and a schedule of events
    int            m_busy, m_reading, m_n, m_k, m_fd_at;
    logic [AW-1:0] m_base, m_addr;
    logic [7:0]    m_r, m_g, m_b;
    px_t           pend[$];
    px_t           done_log[$];
    rd_t           rd_log[$];
    int            fd_log[$];

    task automatic model_reset();
        m_busy = 0; m_reading = 0; m_n = 0; m_k = 0; m_fd_at = -1;
        m_base = '0; m_addr = '0;
        m_r = '0; m_g = '0; m_b = '0;
        pend.delete();
    endtask

    initial model_reset();

    always @(negedge clk) begin : cmp
        logic e_rd, e_done, e_fd, e_busy;
        px_t  p;
        if (bus.mem_rd_o === 1'b1) rd_log.push_back('{cyc, bus.mem_addr_o});
        if (bus.cam_done_o === 1'b1)
            done_log.push_back('{cyc, bus.cam_red_o, bus.cam_green_o, bus.cam_blue_o});
        if (frame_done_o === 1'b1) fd_log.push_back(cyc);
        e_rd = 0; e_done = 0; e_fd = 0; e_busy = 0;
        if (rst) begin
            model_reset();
        end else begin
            e_fd = (m_fd_at == cyc);
            if (e_fd) begin m_busy = 0; m_fd_at = -1; end
            if (pend.size() > 0 && pend[0].at == cyc) begin
                p = pend.pop_front();
                m_r = p.r; m_g = p.g; m_b = p.b;
                e_done = 1;
            end
            e_busy = (m_busy != 0);
            e_rd = (m_reading != 0) && !pause_i;
            if (e_rd) begin
                m_addr = AW'(m_base + m_k);
                if (m_k % BYTES_PER_PX == 2)
                    pend.push_back('{cyc + 2, mem_at(m_addr),
                                     mem_at(AW'(m_addr - 1)), mem_at(AW'(m_addr - 2))});
                m_k++;
                if (m_k == BYTES_PER_PX * m_n) begin
                    m_reading = 0;
                    m_fd_at = cyc + 3;
                end
            end
            if (m_busy == 0 && start_i) begin
                if (pixel_count_i != 0) begin
                    m_busy = 1; m_reading = 1; m_k = 0;
                    m_base = base_addr_i; m_n = int'(pixel_count_i);
                end else begin
                    m_fd_at = cyc + 1;
                end
            end
        end
        chk("mem_rd", 32'(bus.mem_rd_o), 32'(e_rd));
        chk("mem_addr", 32'(bus.mem_addr_o), 32'(m_addr));
        chk("cam_done", 32'(bus.cam_done_o), 32'(e_done));
        chk("cam_red", 32'(bus.cam_red_o), 32'(m_r));
        chk("cam_green", 32'(bus.cam_green_o), 32'(m_g));
        chk("cam_blue", 32'(bus.cam_blue_o), 32'(m_b));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("frame_done", 32'(frame_done_o), 32'(e_fd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete(); done_log.delete(); fd_log.delete();
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] n,
                               output int s);
        start_i = 1'b1; base_addr_i = b; pixel_count_i = n; s = cyc;
        tick();
        start_i = 1'b0;
        base_addr_i = AW'($urandom);
        pixel_count_i = AW'($urandom);
    endtask

    task automatic wait_fd(input int max, input string tag, input bit rnd);
        int n0;
        bit seen;
        n0 = fd_log.size();
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            if (rnd) begin
                pause_i = ($urandom_range(0, 9) < 3);
                if (busy_o && $urandom_range(0, 5) == 0) begin
                    start_i = 1'b1;
                    base_addr_i = AW'($urandom);
                    pixel_count_i = AW'($urandom_range(0, 3));
                end else begin
                    start_i = 1'b0;
                end
            end
            tick();
            seen = (fd_log.size() > n0);
        end
        start_i = 1'b0;
        pause_i = 1'b0;
        if (!seen) chk({tag, "_timeout"}, 1, 0);
    endtask

    task automatic chk_px(input string tag, input int idx, input int at,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (idx < done_log.size()) begin
            chk({tag, "_at"}, done_log[idx].at, at);
            chk({tag, "_r"}, 32'(done_log[idx].r), 32'(r));
            chk({tag, "_g"}, 32'(done_log[idx].g), 32'(g));
            chk({tag, "_b"}, 32'(done_log[idx].b), 32'(b));
        end else begin
            chk({tag, "_missing"}, done_log.size(), idx + 1);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [AW-1:0] rb;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_logs();
        repeat (6) tick();
        chk("idle_reads", rd_log.size(), 0);
        chk("idle_busy", 32'(busy_o), 0);

        // Two-pixel frame, no pause
        clear_logs();
        start_frame(23'd54, 23'd2, s);
        wait_fd(60, "basic", 0);
        chk("basic_nrd", rd_log.size(), 6);
        for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
            chk("basic_rd_at", rd_log[i].at, s + 1 + i);
            chk("basic_rd_addr", 32'(rd_log[i].a), 54 + i);
        end
        chk("basic_ndone", done_log.size(), 2);
        chk_px("basic_px0", 0, s + 5, 8'd30, 8'd20, 8'd10);
        chk_px("basic_px1", 1, s + 8, 8'd60, 8'd50, 8'd40);
        chk("basic_nfd", fd_log.size(), 1);
        if (fd_log.size() > 0) chk("basic_fd_at", fd_log[0], s + 9);
        tick();

        // Pause for four cycles right after the G read of pixel 0
        clear_logs();
        start_frame(23'd54, 23'd2, s);
        tick();
        tick();
        pause_i = 1'b1;
        repeat (4) tick();
        pause_i = 1'b0;
        wait_fd(60, "pause", 0);
        chk("pause_ndone", done_log.size(), 2);
        chk_px("pause_px0", 0, s + 9, 8'd30, 8'd20, 8'd10);
        chk_px("pause_px1", 1, s + 12, 8'd60, 8'd50, 8'd40);
        if (fd_log.size() > 0) chk("pause_fd_at", fd_log[0], s + 13);
        tick();

        // Zero-pixel frame
        clear_logs();
        start_frame(23'd54, 23'd0, s);
        wait_fd(10, "zero", 0);
        chk("zero_nfd", fd_log.size(), 1);
        if (fd_log.size() > 0) chk("zero_fd_at", fd_log[0], s + 1);
        chk("zero_nrd", rd_log.size(), 0);
        chk("zero_ndone", done_log.size(), 0);
        tick();

        // Reset during the second pixel
        clear_logs();
        start_frame(23'd54, 23'd2, s);
        repeat (4) tick();
        rst = 1'b1;
        clear_logs();
        #1;
        chk("rst_cam_red", 32'(bus.cam_red_o), 0);
        chk("rst_cam_done", 32'(bus.cam_done_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rst_ndone", done_log.size(), 0);
        chk("rst_nfd", fd_log.size(), 0);
        clear_logs();
        start_frame(23'd54, 23'd1, s);
        wait_fd(40, "rst_after", 0);
        chk("rst_after_ndone", done_log.size(), 1);
        chk_px("rst_after_px", 0, s + 5, 8'd30, 8'd20, 8'd10);
        tick();

        // Address wrap at the top of the byte space
        clear_logs();
        start_frame(23'h7FFFFE, 23'd1, s);
        wait_fd(40, "wrap", 0);
        chk("wrap_nrd", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            chk("wrap_a0", 32'(rd_log[0].a), 32'h7FFFFE);
            chk("wrap_a1", 32'(rd_log[1].a), 32'h7FFFFF);
            chk("wrap_a2", 32'(rd_log[2].a), 32'h000000);
        end
        chk("wrap_ndone", done_log.size(), 1);
        chk_px("wrap_px", 0, s + 5, mem_at(23'h000000), mem_at(23'h7FFFFF),
               mem_at(23'h7FFFFE));
        tick();

        // Randomized frames with pauses and ignored starts
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 0) rb = AW'($urandom);
            else rb = AW'(23'h7FFFF0 + $urandom_range(0, 15));
            start_frame(rb, AW'($urandom_range(0, 6)), s);
            wait_fd(400, "rnd", 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
